// File: rtl/conv_layer_sequencer.sv
// Layer-level controller for accelerator_core.
// Walks a conv layer as kernel-group (outer) x channel-group (inner) passes.
// For each pass it fires a start pulse and then waits for the expected number of
// psum-valid pulses plus the engine's data-end. All outputs are registered.
module conv_layer_sequencer #(
  parameter int REG_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [CNT_WIDTH-1:0] i_num_kgroup,
  input  logic [CNT_WIDTH-1:0] i_num_chgroup,
  input  logic [CNT_WIDTH-1:0] i_psum_per_pass,
  input  logic                 i_psum_val,
  input  logic                 i_data_end,
  output logic [REG_WIDTH-1:0] o_conf_ctrl,
  output logic [REG_WIDTH-1:0] o_conf_knx,
  output logic [REG_WIDTH-1:0] o_conf_cnt,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [CNT_WIDTH:0] ONE = 1;

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   num_kg, num_kg_nxt;
  logic [CNT_WIDTH-1:0]   num_cg, num_cg_nxt;
  logic [CNT_WIDTH-1:0]   psum_lim, psum_lim_nxt;
  logic [CNT_WIDTH-1:0]   knx, knx_nxt;
  logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0]   psum_cnt, psum_cnt_nxt;
  logic                   dend, dend_nxt;
  logic [CNT_WIDTH:0]     cnt_inc, knx_inc;
  logic [REG_WIDTH-1:0]   ctrl_nxt;

  // True when idx is the final index of a loop bounded by bound.
  function automatic logic is_last(input logic [CNT_WIDTH-1:0] idx,
                                   input logic [CNT_WIDTH-1:0] bound);
    return ({1'b0, idx} + ONE) == {1'b0, bound};
  endfunction

  assign cnt_inc = {1'b0, cnt} + ONE;
  assign knx_inc = {1'b0, knx} + ONE;

  // State register plus every counter, latched bound and registered output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      num_kg      <= '0;
      num_cg      <= '0;
      psum_lim    <= '0;
      knx         <= '0;
      cnt         <= '0;
      psum_cnt    <= '0;
      dend        <= 1'b0;
      o_conf_ctrl <= '0;
      o_conf_knx  <= '0;
      o_conf_cnt  <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values from
      // before this edge; blocking ones would make the result depend on statement order.
      state       <= state_nxt;
      num_kg      <= num_kg_nxt;
      num_cg      <= num_cg_nxt;
      psum_lim    <= psum_lim_nxt;
      knx         <= knx_nxt;
      cnt         <= cnt_nxt;
      psum_cnt    <= psum_cnt_nxt;
      dend        <= dend_nxt;
      o_conf_ctrl <= ctrl_nxt;
      o_conf_knx  <= REG_WIDTH'(knx_nxt);
      o_conf_cnt  <= REG_WIDTH'(cnt_nxt);
      o_busy      <= (state_nxt != S_IDLE);
      o_done      <= (state_nxt == S_DONE);
    end
  end

  // Next-state, loop counters and pass-completion tracking; abort overrides all.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt    = state;
    num_kg_nxt   = num_kg;
    num_cg_nxt   = num_cg;
    psum_lim_nxt = psum_lim;
    knx_nxt      = knx;
    cnt_nxt      = cnt;
    psum_cnt_nxt = psum_cnt;
    dend_nxt     = dend;

    case (state)
      S_IDLE: begin
        if (i_start) begin
          num_kg_nxt   = i_num_kgroup;
          num_cg_nxt   = i_num_chgroup;
          psum_lim_nxt = i_psum_per_pass;
          knx_nxt      = '0;
          cnt_nxt      = '0;
          state_nxt    = ((i_num_kgroup == '0) || (i_num_chgroup == '0)) ? S_DONE : S_START;
        end
      end
      S_START: begin
        psum_cnt_nxt = '0;
        dend_nxt     = 1'b0;
        state_nxt    = S_RUN;
      end
      S_RUN: begin
        // The psum counter saturates at the limit; a zero limit is met from the outset.
        if (i_psum_val && (psum_cnt < psum_lim)) psum_cnt_nxt = psum_cnt + 1'b1;
        if (i_data_end) dend_nxt = 1'b1;
        if ((psum_cnt_nxt == psum_lim) && dend_nxt) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (!is_last(cnt, num_cg)) begin
          cnt_nxt   = cnt_inc[CNT_WIDTH-1:0];
          state_nxt = S_START;
        end else begin
          cnt_nxt   = '0;
          knx_nxt   = knx_inc[CNT_WIDTH-1:0];
          state_nxt = is_last(knx, num_kg) ? S_DONE : S_START;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Abort returns to IDLE and clears state exactly as a reset would.
    if (i_abort) begin
      state_nxt    = S_IDLE;
      num_kg_nxt   = '0;
      num_cg_nxt   = '0;
      psum_lim_nxt = '0;
      knx_nxt      = '0;
      cnt_nxt      = '0;
      psum_cnt_nxt = '0;
      dend_nxt     = 1'b0;
    end
  end

  // Control word for the core: start pulse and last-channel-group flag.
  always_comb begin
    ctrl_nxt    = '0;
    ctrl_nxt[0] = (state_nxt == S_START);
    ctrl_nxt[1] = (state_nxt inside {S_START, S_RUN, S_NEXT}) && is_last(cnt_nxt, num_cg_nxt);
  end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Self-checking bench for conv_layer_sequencer: vector table of whole layers,
// hand-written corner sequences, and randomized layers against a pass-level model.
module tb_conv_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_abort, i_psum_val, i_data_end;
  logic [15:0] i_num_kgroup, i_num_chgroup, i_psum_per_pass;
  logic [31:0] o_conf_ctrl, o_conf_knx, o_conf_cnt;
  logic        o_busy, o_done;

  int n_checks = 0;
  int n_errors = 0;

  conv_layer_sequencer #(.REG_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .i_num_kgroup   (i_num_kgroup),
    .i_num_chgroup  (i_num_chgroup),
    .i_psum_per_pass(i_psum_per_pass),
    .i_psum_val     (i_psum_val),
    .i_data_end     (i_data_end),
    .o_conf_ctrl    (o_conf_ctrl),
    .o_conf_knx     (o_conf_knx),
    .o_conf_cnt     (o_conf_cnt),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kg;
    int cg;
    int pp;
    int exp_starts;
    int exp_lasts;
  } layer_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic pv, input logic de, input logic ab);
    i_start    = s;
    i_psum_val = pv;
    i_data_end = de;
    i_abort    = ab;
  endtask

  task automatic set_bounds(input int kg, input int cg, input int pp);
    i_num_kgroup    = 16'(kg);
    i_num_chgroup   = 16'(cg);
    i_psum_per_pass = 16'(pp);
  endtask

  task automatic expect_out(input string name, input int ctrl, input int knx, input int cnt,
                            input int busy, input int done);
    check({name, ".ctrl"}, o_conf_ctrl, 32'(ctrl));
    check({name, ".knx"},  o_conf_knx,  32'(knx));
    check({name, ".cnt"},  o_conf_cnt,  32'(cnt));
    check({name, ".busy"}, 32'(o_busy), 32'(busy));
    check({name, ".done"}, 32'(o_done), 32'(done));
  endtask

  // Only control, busy and done: index values after the final pass are not of interest.
  task automatic expect_ctl(input string name, input int ctrl, input int busy, input int done);
    check({name, ".ctrl"}, o_conf_ctrl, 32'(ctrl));
    check({name, ".busy"}, 32'(o_busy), 32'(busy));
    check({name, ".done"}, 32'(o_done), 32'(done));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    layer_vec_t vecs[6];
    int starts, lasts, dones, cyc;

    vecs[0] = '{kg: 2, cg: 2, pp: 4, exp_starts: 4, exp_lasts: 2};
    vecs[1] = '{kg: 0, cg: 3, pp: 1, exp_starts: 0, exp_lasts: 0};
    vecs[2] = '{kg: 2, cg: 0, pp: 2, exp_starts: 0, exp_lasts: 0};
    vecs[3] = '{kg: 1, cg: 3, pp: 0, exp_starts: 3, exp_lasts: 1};
    vecs[4] = '{kg: 3, cg: 1, pp: 2, exp_starts: 3, exp_lasts: 3};
    vecs[5] = '{kg: 1, cg: 1, pp: 1, exp_starts: 1, exp_lasts: 1};

    // ---------------- reset ----------------
    rst = 1'b0;
    drive(0, 0, 0, 0);
    set_bounds(0, 0, 0);
    #12;
    expect_out("reset", 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    expect_out("post_reset_idle", 0, 0, 0, 0, 0);

    // ---------------- table-driven whole layers ----------------
    foreach (vecs[v]) begin
      set_bounds(vecs[v].kg, vecs[v].cg, vecs[v].pp);
      drive(1, 0, 0, 0);
      tick();
      drive(0, 1, 1, 0);
      starts = 0; lasts = 0; dones = 0; cyc = 0;
      while (cyc < 200) begin
        if (o_conf_ctrl[0]) starts++;
        if (o_conf_ctrl[0] && o_conf_ctrl[1]) lasts++;
        if (o_done) dones++;
        if (!o_busy) break;
        tick();
        cyc++;
      end
      check($sformatf("tbl%0d.bound", v), 32'(cyc < 200), 32'd1);
      check($sformatf("tbl%0d.starts", v), starts, vecs[v].exp_starts);
      check($sformatf("tbl%0d.lasts", v), lasts, vecs[v].exp_lasts);
      check($sformatf("tbl%0d.dones", v), dones, 1);
      drive(0, 0, 0, 0);
      tick();
    end

    // ---------------- zero bound: straight to DONE ----------------
    set_bounds(0, 5, 2);
    drive(1, 0, 0, 0);
    tick();
    expect_out("zero.done", 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0);
    tick();
    expect_out("zero.idle", 0, 0, 0, 0, 0);

    // ---------------- psum/data_end ordering, saturation ----------------
    set_bounds(1, 3, 3);
    drive(1, 0, 0, 0); tick(); expect_out("ord.p1_start", 1, 0, 0, 1, 0);
    drive(0, 0, 0, 0); tick(); expect_out("ord.p1_run", 0, 0, 0, 1, 0);
    drive(0, 0, 1, 0); tick(); expect_out("ord.p1_de_first", 0, 0, 0, 1, 0);
    drive(0, 1, 0, 0); tick(); expect_out("ord.p1_psum1", 0, 0, 0, 1, 0);
    drive(0, 1, 0, 0); tick(); expect_out("ord.p1_psum2", 0, 0, 0, 1, 0);
    drive(0, 1, 0, 0); tick(); expect_out("ord.p1_next", 0, 0, 0, 1, 0);
    drive(0, 1, 0, 0); tick(); expect_out("ord.p2_start", 1, 0, 1, 1, 0);
    drive(0, 0, 0, 0); tick(); expect_out("ord.p2_run", 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0); tick(); expect_out($sformatf("ord.p2_psum%0d", i), 0, 0, 1, 1, 0);
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0); tick(); expect_out($sformatf("ord.p2_wait%0d", i), 0, 0, 1, 1, 0);
    end
    drive(0, 0, 1, 0); tick(); expect_out("ord.p2_next", 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0); tick(); expect_out("ord.p3_start", 3, 0, 2, 1, 0);
    drive(0, 0, 0, 0); tick(); expect_out("ord.p3_run", 2, 0, 2, 1, 0);
    drive(0, 1, 0, 0); tick(); expect_out("ord.p3_psum1", 2, 0, 2, 1, 0);
    drive(0, 1, 0, 0); tick(); expect_out("ord.p3_psum2", 2, 0, 2, 1, 0);
    drive(0, 1, 1, 0); tick(); expect_out("ord.p3_next", 2, 0, 2, 1, 0);
    drive(0, 0, 0, 0); tick(); expect_ctl("ord.done", 0, 1, 1);
    drive(0, 0, 0, 0); tick(); expect_ctl("ord.idle", 0, 0, 0);

    // ---------------- abort during RUN of pass 2 ----------------
    set_bounds(2, 2, 1);
    drive(1, 0, 0, 0); tick(); expect_out("abt.p1_start", 1, 0, 0, 1, 0);
    drive(0, 0, 0, 0); tick(); expect_out("abt.p1_run", 0, 0, 0, 1, 0);
    drive(0, 1, 1, 0); tick(); expect_out("abt.p1_next", 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0); tick(); expect_out("abt.p2_start", 3, 0, 1, 1, 0);
    drive(0, 0, 0, 0); tick(); expect_out("abt.p2_run", 2, 0, 1, 1, 0);
    drive(0, 0, 0, 1); tick(); expect_out("abt.cleared", 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 1, 0); tick(); expect_out($sformatf("abt.quiet%0d", i), 0, 0, 0, 0, 0);
    end
    drive(1, 0, 0, 0); tick(); expect_out("abt.restart", 1, 0, 0, 1, 0);
    drive(0, 0, 0, 0); tick(); expect_out("abt.restart_run", 0, 0, 0, 1, 0);

    // ---------------- asynchronous reset mid-RUN ----------------
    #3;
    rst = 1'b0;
    #1;
    expect_out("areset.immediate", 0, 0, 0, 0, 0);
    tick();
    expect_out("areset.held", 0, 0, 0, 0, 0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 0); tick(); expect_out($sformatf("areset.idle%0d", i), 0, 0, 0, 0, 0);
    end

    // ---------------- randomized layers vs pass-level model ----------------
    for (int l = 0; l < 40; l++) begin
      int kg, cg, pp;
      kg = int'($urandom_range(0, 3));
      cg = int'($urandom_range(0, 3));
      pp = int'($urandom_range(0, 4));
      set_bounds(kg, cg, pp);
      drive(1, 0, 0, 0);
      tick();
      // Model: nested loops over kernel group k and channel group c; each pass ends
      // once pp psum pulses (extras ignored) and one data_end have been seen in RUN.
      for (int k = 0; k < kg && cg != 0; k++) begin
        for (int c = 0; c < cg; c++) begin
          int seen, guard, last;
          bit flag, met;
          last = (c == cg - 1) ? 2 : 0;
          expect_out($sformatf("rnd%0d.start_k%0d_c%0d", l, k, c), last | 1, k, c, 1, 0);
          // Pulses and bound changes while the start pulse is out must be ignored.
          i_num_kgroup    = 16'($urandom);
          i_num_chgroup   = 16'($urandom);
          i_psum_per_pass = 16'($urandom);
          drive(1'($urandom), 1'($urandom), 1'($urandom), 0);
          tick();
          seen = 0; flag = 0; met = 0; guard = 0;
          while (!met && guard < 200) begin
            expect_out($sformatf("rnd%0d.run_k%0d_c%0d", l, k, c), last, k, c, 1, 0);
            drive(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 0);
            tick();
            if (i_psum_val && seen < pp) seen++;
            if (i_data_end) flag = 1;
            met = (seen >= pp) && flag;
            guard++;
          end
          check($sformatf("rnd%0d.pass_bound", l), 32'(guard < 200), 32'd1);
          expect_out($sformatf("rnd%0d.next_k%0d_c%0d", l, k, c), last, k, c, 1, 0);
          drive(1'($urandom), 1'($urandom), 1'($urandom), 0);
          tick();
        end
      end
      expect_ctl($sformatf("rnd%0d.done", l), 0, 1, 1);
      drive(1'($urandom), 1'($urandom), 1'($urandom), 0);
      tick();
      expect_ctl($sformatf("rnd%0d.idle", l), 0, 0, 0);
      drive(0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
